// File: rtl/ex_alu_pipe.sv
// ex_alu_pipe: pipelined RV32I/RV64I integer ALU with valid/ready stages; RV64 word ops enabled by EX_ALU_WOPS_EN
module ex_alu_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);
  localparam int SW = (XLEN == 64) ? 6 : 5;
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("ex_alu_pipe: XLEN must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("ex_alu_pipe: STAGES must be 1..3");
  end
  logic [XLEN-1:0]  base_res;
  logic [XLEN-1:0]  alu_res;
  logic             base_ok;
  logic             wsel;
  logic             w_ok;
  logic             alu_ill;
  logic [63:0]      w_ext;
  logic [SW-1:0]    sh;
  logic [STAGES:0]  go;
  logic [STAGES-1:0] v_q, v_d, ill_q, ill_d;
  logic [XLEN-1:0]  res_q [STAGES];
  logic [XLEN-1:0]  res_d [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];
  logic [TAG_W-1:0] tag_d [STAGES];
  assign sh   = op_b_i[SW-1:0];
  assign wsel = word_i && (XLEN == 64);
  // Full-width RV32I/RV64I register/immediate operations
  always_comb begin
    base_res = '0;
    base_ok  = 1'b1;
    case (op_i)
      4'b0000: base_res = op_a_i + op_b_i;
      4'b1000: base_res = op_a_i - op_b_i;
      4'b0001: base_res = op_a_i << sh;
      4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
      4'b0011: base_res = {{(XLEN-1){1'b0}}, op_a_i < op_b_i};
      4'b0100: base_res = op_a_i ^ op_b_i;
      4'b0101: base_res = op_a_i >> sh;
      4'b1101: base_res = $signed(op_a_i) >>> sh;
      4'b0110: base_res = op_a_i | op_b_i;
      4'b0111: base_res = op_a_i & op_b_i;
      default: base_ok = 1'b0;
    endcase
  end
`ifdef EX_ALU_WOPS_EN
  logic [31:0] w32;
  logic [4:0]  wsh;
  assign wsh = op_b_i[4:0];
  // 32-bit word ops on the low half; result is sign-extended below
  always_comb begin
    w32  = '0;
    w_ok = 1'b1;
    case (op_i)
      4'b0000: w32 = op_a_i[31:0] + op_b_i[31:0];
      4'b1000: w32 = op_a_i[31:0] - op_b_i[31:0];
      4'b0001: w32 = op_a_i[31:0] << wsh;
      4'b0101: w32 = op_a_i[31:0] >> wsh;
      4'b1101: w32 = $signed(op_a_i[31:0]) >>> wsh;
      default: w_ok = 1'b0;
    endcase
  end
  assign w_ext = {{32{w32[31]}}, w32};
`else
  assign w_ok  = 1'b0;
  assign w_ext = '0;
`endif
  assign alu_ill = wsel ? !w_ok : !base_ok;
  assign alu_res = alu_ill ? '0 : (wsel ? w_ext[XLEN-1:0] : base_res);
  // Load enables ripple back from the consumer: a stage loads when empty or when the stage after it loads
  always_comb begin
    go = '0;
    go[STAGES] = ready_i;
    for (int k = STAGES - 1; k >= 0; k--) go[k] = !v_q[k] || go[k+1];
  end
  // Each stage's load source is the ALU (stage 0) or the stage before it
  always_comb begin
    v_d[0]   = valid_i;
    ill_d[0] = alu_ill;
    res_d[0] = alu_res;
    tag_d[0] = tag_i;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k]   = v_q[k-1];
      ill_d[k] = ill_q[k-1];
      res_d[k] = res_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
  end
  // Stage registers: payload only changes on a stage load, so stalled stages hold
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst_i) begin
        v_q[k]   <= 1'b0;
        ill_q[k] <= 1'b0;
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end else if (go[k]) begin
        v_q[k]   <= v_d[k];
        ill_q[k] <= ill_d[k];
        res_q[k] <= res_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
  end
  assign ready_o   = go[0];
  assign valid_o   = v_q[STAGES-1];
  assign illegal_o = ill_q[STAGES-1];
  assign result_o  = res_q[STAGES-1];
  assign tag_o     = tag_q[STAGES-1];
endmodule

// File: tb/tb_ex_alu_pipe.sv
// tb_ex_alu_pipe: directed bench for ex_alu_pipe at STAGES=1, 2 and 3 (XLEN=64)
module tb_ex_alu_pipe;
`ifdef EX_ALU_WOPS_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif
  typedef struct {
    logic [3:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
    logic        il;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  logic a_vi, a_ro, a_w, a_vo, a_ri, a_il;
  logic [3:0] a_op;
  logic [63:0] a_a, a_b, a_r;
  logic [4:0] a_t, a_to;
  logic b_vi, b_ro, b_w, b_vo, b_ri, b_il;
  logic [3:0] b_op;
  logic [63:0] b_a, b_b, b_r;
  logic [4:0] b_t, b_to;
  logic c_vi, c_ro, c_w, c_vo, c_ri, c_il;
  logic [3:0] c_op;
  logic [63:0] c_a, c_b, c_r;
  logic [4:0] c_t, c_to;
  ex_alu_pipe #(.XLEN(64), .STAGES(1), .TAG_W(5)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(a_vi), .ready_o(a_ro), .op_i(a_op), .word_i(a_w),
    .op_a_i(a_a), .op_b_i(a_b), .tag_i(a_t), .valid_o(a_vo), .ready_i(a_ri),
    .result_o(a_r), .tag_o(a_to), .illegal_o(a_il));
  ex_alu_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) u2 (
    .clk_i(clk), .rst_i(rst), .valid_i(b_vi), .ready_o(b_ro), .op_i(b_op), .word_i(b_w),
    .op_a_i(b_a), .op_b_i(b_b), .tag_i(b_t), .valid_o(b_vo), .ready_i(b_ri),
    .result_o(b_r), .tag_o(b_to), .illegal_o(b_il));
  ex_alu_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5)) u3 (
    .clk_i(clk), .rst_i(rst), .valid_i(c_vi), .ready_o(c_ro), .op_i(c_op), .word_i(c_w),
    .op_a_i(c_a), .op_b_i(c_b), .tag_i(c_t), .valid_o(c_vo), .ready_i(c_ri),
    .result_o(c_r), .tag_o(c_to), .illegal_o(c_il));
  function automatic vec_t mk(logic [3:0] op, logic w, logic [63:0] a, logic [63:0] b, logic [63:0] e, logic il);
    vec_t v;
    v.op = op; v.w = w; v.a = a; v.b = b; v.e = e; v.il = il;
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    a_vi = 1'b1; b_vi = 1'b1; c_vi = 1'b1;
    a_ri = 1'b1; b_ri = 1'b1; c_ri = 1'b1;
    a_op = 4'b0000; b_op = 4'b0000; c_op = 4'b0000;
    a_w = 1'b0; b_w = 1'b0; c_w = 1'b0;
    a_a = 64'd5; b_a = 64'd5; c_a = 64'd5;
    a_b = 64'd5; b_b = 64'd5; c_b = 64'd5;
    a_t = 5'd3; b_t = 5'd3; c_t = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({a_vo, b_vo, c_vo} !== 3'b000 || {a_r, b_r, c_r} !== 192'd0 || {a_to, b_to, c_to} !== 15'd0) begin
        bad++;
        $display("FAIL reset[%0d] valid=%b%b%b tag=%0d/%0d/%0d result=%h/%h/%h want all 0",
                 i, a_vo, b_vo, c_vo, a_to, b_to, c_to, a_r, b_r, c_r);
      end
    end
    rst = 1'b0;
    a_vi = 1'b0; b_vi = 1'b0; c_vi = 1'b0;
    tick();
    total++;
    if ({a_ro, b_ro, c_ro} !== 3'b111) begin
      bad++;
      $display("FAIL reset_ready ready=%b%b%b want 111", a_ro, b_ro, c_ro);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({a_vo, b_vo, c_vo} !== 3'b000) begin
        bad++;
        $display("FAIL reset_ghost[%0d] valid=%b%b%b want 000", i, a_vo, b_vo, c_vo);
      end
      tick();
    end
  endtask
  task automatic test_arith();
    vec_t v[13];
    v[0]  = mk(4'b0000, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0);
    v[1]  = mk(4'b1000, 0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    v[2]  = mk(4'b0010, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0);
    v[3]  = mk(4'b0011, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0);
    v[4]  = mk(4'b1101, 0, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 0);
    v[5]  = mk(4'b0001, 0, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 0);
    v[6]  = mk(4'b0101, 0, 64'h8000_0000_0000_0000, 64'h44, 64'h0800_0000_0000_0000, 0);
    v[7]  = mk(4'b0100, 0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 0);
    v[8]  = mk(4'b0110, 0, 64'h00F0, 64'h0F00, 64'h0FF0, 0);
    v[9]  = mk(4'b0111, 0, 64'hFF0F, 64'h0FFF, 64'h0F0F, 0);
    v[10] = mk(4'b0011, 0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    v[11] = mk(4'b1111, 0, 64'd5, 64'd5, 64'd0, 1);
    v[12] = mk(4'b1001, 0, 64'd5, 64'd5, 64'd0, 1);
    a_ri = 1'b1;
    for (int i = 0; i < 13; i++) begin
      a_vi = 1'b1; a_op = v[i].op; a_w = v[i].w; a_a = v[i].a; a_b = v[i].b; a_t = 5'(i + 1);
      tick();
      a_vi = 1'b0;
      total++;
      if (a_vo !== 1'b1 || a_r !== v[i].e || a_il !== v[i].il || a_to !== 5'(i + 1)) begin
        bad++;
        $display("FAIL arith[%0d] got v=%b r=%h il=%b tag=%0d want v=1 r=%h il=%b tag=%0d",
                 i, a_vo, a_r, a_il, a_to, v[i].e, v[i].il, i + 1);
      end
    end
    tick();
    total++;
    if (a_vo !== 1'b0) begin
      bad++;
      $display("FAIL arith_drain valid=%b want 0", a_vo);
    end
  endtask
  task automatic test_word();
    vec_t v[8];
    v[0] = mk(4'b0000, 1, 64'h7FFF_FFFF, 64'd1, WEN ? 64'hFFFF_FFFF_8000_0000 : 64'd0, !WEN);
    v[1] = mk(4'b0101, 1, 64'hFFFF_FFFF_8000_0000, 64'd31, WEN ? 64'd1 : 64'd0, !WEN);
    v[2] = mk(4'b0100, 1, 64'h1234, 64'h4321, 64'd0, 1);
    v[3] = mk(4'b1000, 1, 64'd0, 64'd1, WEN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0, !WEN);
    v[4] = mk(4'b0001, 1, 64'd1, 64'd31, WEN ? 64'hFFFF_FFFF_8000_0000 : 64'd0, !WEN);
    v[5] = mk(4'b1101, 1, 64'h1234_5678_8000_0000, 64'h24, WEN ? 64'hFFFF_FFFF_F800_0000 : 64'd0, !WEN);
    v[6] = mk(4'b0000, 1, 64'hDEAD_0000_0000_0001, 64'd2, WEN ? 64'd3 : 64'd0, !WEN);
    v[7] = mk(4'b0010, 1, 64'd1, 64'd2, 64'd0, 1);
    a_ri = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_vi = 1'b1; a_op = v[i].op; a_w = v[i].w; a_a = v[i].a; a_b = v[i].b; a_t = 5'(i + 20);
      tick();
      a_vi = 1'b0;
      total++;
      if (a_vo !== 1'b1 || a_r !== v[i].e || a_il !== v[i].il || a_to !== 5'(i + 20)) begin
        bad++;
        $display("FAIL word[%0d] got v=%b r=%h il=%b tag=%0d want v=1 r=%h il=%b tag=%0d",
                 i, a_vo, a_r, a_il, a_to, v[i].e, v[i].il, i + 20);
      end
    end
    a_w = 1'b0;
    tick();
  endtask
  task automatic test_back_to_back();
    int nxt = 1;
    int got[$];
    int cyc[$];
    logic r;
    logic acc;
    c_ri = 1'b0; c_op = 4'b0000; c_w = 1'b0; c_b = 64'd100;
    for (int i = 0; i < 6; i++) begin
      c_vi = 1'b1; c_t = 5'(nxt); c_a = 64'(nxt);
      #1;
      r = c_ro;
      @(posedge clk);
      if (r) nxt++;
      #1;
    end
    total++;
    if (nxt !== 4 || c_ro !== 1'b0) begin
      bad++;
      $display("FAIL bp_fill accepted=%0d ready=%b want accepted=3 ready=0", nxt - 1, c_ro);
    end
    total++;
    if (c_vo !== 1'b1 || c_to !== 5'd1 || c_r !== 64'd101) begin
      bad++;
      $display("FAIL bp_hold v=%b tag=%0d r=%0d want v=1 tag=1 r=101", c_vo, c_to, c_r);
    end
    c_ri = 1'b1;
    for (int t = 0; t < 20 && got.size() < 5; t++) begin
      c_vi = (nxt <= 5); c_t = 5'(nxt); c_a = 64'(nxt);
      #1;
      acc = c_vi && c_ro;
      if (c_vo) begin
        got.push_back(int'(c_to));
        cyc.push_back(t);
        total++;
        if (c_r !== 64'(int'(c_to) + 100) || c_il !== 1'b0) begin
          bad++;
          $display("FAIL bp_result tag=%0d r=%0d il=%b want r=%0d il=0", c_to, c_r, c_il, int'(c_to) + 100);
        end
      end
      @(posedge clk);
      if (acc) nxt++;
      #1;
    end
    c_vi = 1'b0;
    total++;
    if (got.size() != 5) begin
      bad++;
      $display("FAIL bp_count got=%0d want 5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (got[k] != k + 1 || cyc[k] != cyc[0] + k) begin
          bad++;
          $display("FAIL bp_order[%0d] tag=%0d cycle=%0d want tag=%0d cycle=%0d", k, got[k], cyc[k], k + 1, cyc[0] + k);
        end
      end
    end
    tick();
    tick();
  endtask
  task automatic test_bubble();
    b_ri = 1'b0; b_op = 4'b0000; b_w = 1'b0; b_b = 64'd0;
    b_vi = 1'b1; b_t = 5'd11; b_a = 64'd11;
    tick();
    b_vi = 1'b0;
    tick();
    total++;
    if (b_vo !== 1'b1 || b_to !== 5'd11) begin
      bad++;
      $display("FAIL bubble_s2 v=%b tag=%0d want v=1 tag=11", b_vo, b_to);
    end
    b_vi = 1'b1; b_t = 5'd12; b_a = 64'd12;
    #1;
    total++;
    if (b_ro !== 1'b1) begin
      bad++;
      $display("FAIL bubble_ready ready=%b want 1", b_ro);
    end
    @(posedge clk);
    #1;
    total++;
    if (b_ro !== 1'b0 || b_vo !== 1'b1 || b_to !== 5'd11 || b_r !== 64'd11) begin
      bad++;
      $display("FAIL bubble_full ready=%b v=%b tag=%0d r=%0d want ready=0 v=1 tag=11 r=11", b_ro, b_vo, b_to, b_r);
    end
    b_vi = 1'b0; b_ri = 1'b1;
    tick();
    total++;
    if (b_vo !== 1'b1 || b_to !== 5'd12 || b_r !== 64'd12) begin
      bad++;
      $display("FAIL bubble_drain v=%b tag=%0d r=%0d want v=1 tag=12 r=12", b_vo, b_to, b_r);
    end
    tick();
    total++;
    if (b_vo !== 1'b0) begin
      bad++;
      $display("FAIL bubble_empty v=%b want 0", b_vo);
    end
  endtask
  task automatic test_reset_mid();
    c_ri = 1'b0; c_op = 4'b0000; c_w = 1'b0; c_b = 64'd0;
    for (int i = 0; i < 3; i++) begin
      c_vi = 1'b1; c_t = 5'(7 + i); c_a = 64'(7 + i);
      tick();
    end
    c_vi = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c_ri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (c_vo !== 1'b0 || c_ro !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_flush[%0d] v=%b ready=%b tag=%0d want v=0 ready=1", i, c_vo, c_ro, c_to);
      end
      tick();
    end
    c_vi = 1'b1; c_op = 4'b1000; c_t = 5'd20; c_a = 64'h1234; c_b = 64'h1;
    tick();
    c_vi = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (c_vo !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_early[%0d] v=%b want 0", i, c_vo);
      end
      if (i == 0) tick();
    end
    tick();
    total++;
    if (c_vo !== 1'b1 || c_r !== 64'h1233 || c_to !== 5'd20 || c_il !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_result v=%b r=%h tag=%0d il=%b want v=1 r=1233 tag=20 il=0", c_vo, c_r, c_to, c_il);
    end
  endtask
  initial begin
    test_reset();
    test_arith();
    test_word();
    test_back_to_back();
    test_bubble();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
